// File: rtl/seg_pkg.sv
// Shared definitions for the BCD display scanner: active-low segment
// patterns, converter FSM encodings and the nibble-to-segment decoder.
package seg_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; one bit per cycle,
// result held on bcd and flagged by done for a single cycle.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SH_W   = BCD_W + BIN_W;
  localparam int ITER_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  conv_state_e       state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              busy_q, busy_d;
  logic [SH_W-1:0]   adj;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    adj     = sh_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = {{BCD_W{1'b0}}, bin};
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (adj[BIN_W+4*i +: 4] >= 4'd5) begin
            adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
          end
        end
        sh_d   = {adj[SH_W-2:0], 1'b0};
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BIN_W - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = busy_q;
    done = (state_q == S_COMMIT);
    bcd  = sh_q[SH_W-1 -: BCD_W];
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Converts a binary value to BCD and scans it onto a common-anode 7-segment
// display, one digit per en_1k tick, with leading-zero blanking.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_1k,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin,
  output logic              busy,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_done;

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   blank;
  logic                nz_above;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rstn  (rstn),
    .start (load),
    .bin   (bin),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // The display register only ever takes a completed conversion.
  always_comb begin
    disp_d = conv_done ? conv_bcd : disp_q;
    idx_d  = idx_q;
    if (en_1k) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is blanked when it and all higher digits are zero; digit 0 never is.
  always_comb begin
    nz_above = 1'b0;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_above = nz_above | (disp_q[4*i +: 4] != 4'd0);
      blank[i] = (i != 0) && !nz_above;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i) && !blank[i]) begin
        an_d  = ~(DIGITS'(1) << i);
        seg_d = seg_decode(disp_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      disp_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_OFF;
    end else begin
      disp_q <= disp_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomized and directed bench for seg_display_scanner against a decimal
// arithmetic model of the conversion, scan and blanking behaviour.
module tb_seg_display_scanner;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic             clk = 1'b0;
  logic             rstn, en_1k, load;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic [2:0]       an;
  logic [6:0]       seg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  // Model state: expected registered outputs plus displayed value and scan index.
  logic [2:0] m_an;
  logic [6:0] m_seg;
  bit         m_busy;
  int         m_cnt, m_disp, m_pend, m_idx;

  seg_display_scanner #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .en_1k (en_1k),
    .load  (load),
    .bin   (bin),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(input int idx, input int val,
                                    output logic [2:0] a, output logic [6:0] s);
    int p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (idx > 0 && val < p) begin
      a = 3'b111;
      s = 7'h7F;
    end else begin
      a = ~(3'b001 << idx);
      s = pat[(val / p) % 10];
    end
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_an = 3'b111; m_seg = 7'h7F; m_busy = 0;
      m_cnt = 0; m_disp = 0; m_idx = 0;
    end else begin
      model_out(m_idx, m_disp, m_an, m_seg);
      if (en_1k) m_idx = (m_idx + 1) % DIGITS;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_disp = m_pend;
          m_busy = 0;
        end
      end else if (load) begin
        m_pend = int'(bin);
        m_cnt  = BIN_W + 1;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("an",   int'(an),   int'(m_an));
      check("seg",  int'(seg),  int'(m_seg));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    bin  = BIN_W'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Step the scan until digit d is selected, then let the output register catch up.
  task automatic show(input int d);
    for (int n = 0; n < 8 && m_idx != d; n++) begin
      en_1k = 1'b1;
      tick();
      en_1k = 1'b0;
    end
    tick();
  endtask

  task automatic lit(input string name, input logic [2:0] ea, input logic [6:0] es);
    check({name, "_an"},  int'(an),  int'(ea));
    check({name, "_seg"}, int'(seg), int'(es));
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; load = 1'b1; en_1k = 1'b1; bin = 8'hAA;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy", int'(busy), 0);
    lit("rst", 3'b111, 7'h7F);
    rstn = 1'b1; load = 1'b0; en_1k = 1'b0;
    tick();
    lit("post_rst", 3'b110, 7'b1000000);

    do_load(225);
    cnt = 0;
    for (int n = 0; n < 20 && busy; n++) begin
      cnt++;
      tick();
    end
    check("busy_len", cnt, 9);
    show(0); lit("d225_0", 3'b110, 7'b0010010);
    show(1); lit("d225_1", 3'b101, 7'b0100100);
    show(2); lit("d225_2", 3'b011, 7'b0100100);
    show(0); lit("d225_wrap", 3'b110, 7'b0010010);

    do_load(7); wait_idle();
    show(0); lit("d7_0", 3'b110, 7'b1111000);
    show(1); lit("d7_1", 3'b111, 7'h7F);
    show(2); lit("d7_2", 3'b111, 7'h7F);

    do_load(0); wait_idle();
    show(0); lit("d0_0", 3'b110, 7'b1000000);
    do_load(100); wait_idle();
    show(1); lit("d100_1", 3'b101, 7'b1000000);

    do_load(12); tick(); tick();
    do_load(99); wait_idle();
    show(0); lit("d12_0", 3'b110, 7'b0100100);
    show(1); lit("d12_1", 3'b101, 7'b1111001);

    // Scan tick and a rejected load both land on the commit edge.
    do_load(58);
    repeat (7) tick();
    en_1k = 1'b1; load = 1'b1; bin = 8'd77;
    tick();
    en_1k = 1'b0; load = 1'b0;
    tick();
    en_1k = 1'b1;
    repeat (5) tick();
    en_1k = 1'b0;
    show(1); lit("d58_1", 3'b101, 7'b0010010);

    do_load(200);
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    check("abort_busy", int'(busy), 0);
    rstn = 1'b1;
    tick();
    lit("abort", 3'b110, 7'b1000000);
    do_load(42); wait_idle();
    show(0); lit("d42_0", 3'b110, 7'b0100100);
    show(1); lit("d42_1", 3'b101, 7'b0011001);
    show(2); lit("d42_2", 3'b111, 7'h7F);

    for (int n = 0; n < 2000; n++) begin
      load  = ($urandom_range(0, 7) == 0);
      bin   = BIN_W'($urandom);
      en_1k = ($urandom_range(0, 2) == 0);
      rstn  = ($urandom_range(0, 150) != 0);
      tick();
    end
    rstn = 1'b1; load = 1'b0; en_1k = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
